demux_14_4b_reg: RTL and testbench

Write-side counterpart of the 4:1 4-bit source mux. It routes one 4-bit input word to one of four holding registers selected by sel1/sel0, and presents all four registers on outputs A..D, which feed the mux inputs directly. Writes use a valid/ready handshake. A sequenced clear engine zeroes the bank one register per cycle.

---
 rtl/demux_14_4b_reg.sv | 114 +++++++++++
 tb/tb_demux_14_4b_reg.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/demux_14_4b_reg.sv
// Write-side demux for the 4:1 4-bit source mux: one DIN word is routed to one of four
// holding registers under a valid/ready handshake, with a one-register-per-cycle clear engine.
//
// state | meaning
// IDLE  | accepting writes; clr_req starts a clear
// CLEAR | zeroing register[clr_cnt] each cycle, writes blocked
module demux_14_4b_reg #(
    parameter int unsigned          WIDTH   = 4,
    parameter logic [WIDTH-1:0]     CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] DIN,
    input  logic             sel0,
    input  logic             sel1,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic             clr_req,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       WRITTEN,
    output logic             busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [1:0]       clr_cnt;
    logic [1:0]       idx;
    logic             do_write;
    logic             clr_step;
    logic [WIDTH-1:0] bank [4];
    logic [3:0]       written_q;

    assign idx = {sel1, sel0};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (clr_cnt == 2'd3) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // wr_ready depends only on state and clr_req so that clear always wins over a write
    always_comb begin
        wr_ready = 1'b0;
        clr_step = 1'b0;
        case (state)
            IDLE:    wr_ready = !clr_req;
            CLEAR:   clr_step = 1'b1;
            default: ;
        endcase
    end

    assign do_write = wr_valid && wr_ready;

    // Counter is only advanced in CLEAR; it wraps to 0 on the return edge by natural overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_cnt <= 2'd0;
        end else if (clr_step) begin
            clr_cnt <= clr_cnt + 2'd1;
        end else begin
            clr_cnt <= 2'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt == CLEAR);
        end
    end

    // Reset loads zero rather than CLR_VAL; only the clear sequence uses CLR_VAL
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                bank[i] <= '0;
            end
            written_q <= 4'b0000;
        end else if (clr_step) begin
            bank[clr_cnt]      <= CLR_VAL;
            written_q[clr_cnt] <= 1'b0;
        end else if (do_write) begin
            bank[idx]      <= DIN;
            written_q[idx] <= 1'b1;
        end
    end

    assign A       = bank[0];
    assign B       = bank[1];
    assign C       = bank[2];
    assign D       = bank[3];
    assign WRITTEN = written_q;

endmodule

// File: tb/tb_demux_14_4b_reg.sv
// Self-checking bench for demux_14_4b_reg: directed test-plan scenarios followed by
// randomized traffic, all compared against a countdown-based behavioural model.
module tb_demux_14_4b_reg;

    localparam int         WIDTH   = 4;
    localparam logic [3:0] CLR_VAL = 4'h0;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] DIN;
    logic             sel0, sel1;
    logic             wr_valid;
    logic             wr_ready;
    logic             clr_req;
    logic [WIDTH-1:0] A, B, C, D;
    logic [3:0]       WRITTEN;
    logic             busy;

    int checks = 0;
    int errors = 0;

    // Reference model: bank contents, written flags, and remaining clear cycles
    logic [3:0] m_reg [4];
    logic [3:0] m_written;
    int         m_clr_left;

    demux_14_4b_reg #(.WIDTH(WIDTH), .CLR_VAL(CLR_VAL)) dut (
        .clk      (clk),
        .rst      (rst),
        .DIN      (DIN),
        .sel0     (sel0),
        .sel1     (sel1),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .clr_req  (clr_req),
        .A        (A),
        .B        (B),
        .C        (C),
        .D        (D),
        .WRITTEN  (WRITTEN),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic c, input logic v,
                              input logic [3:0] d, input logic [1:0] s);
        if (r) begin
            for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
            m_written  = 4'b0000;
            m_clr_left = 0;
        end else if (m_clr_left > 0) begin
            m_reg[4 - m_clr_left]     = CLR_VAL;
            m_written[4 - m_clr_left] = 1'b0;
            m_clr_left--;
        end else if (c) begin
            m_clr_left = 4;
        end else if (v) begin
            m_reg[s]     = d;
            m_written[s] = 1'b1;
        end
    endtask

    // One clock: drive, check wr_ready mid-cycle, advance model, check registered outputs
    task automatic step(input logic r, input logic c, input logic v,
                        input logic [3:0] d, input logic [1:0] s);
        rst = r; clr_req = c; wr_valid = v; DIN = d; {sel1, sel0} = s;
        @(negedge clk);
        chk("wr_ready", 32'(wr_ready), 32'((m_clr_left == 0) && !c));
        @(posedge clk);
        model_edge(r, c, v, d, s);
        #1;
        chk("A", 32'(A), 32'(m_reg[0]));
        chk("B", 32'(B), 32'(m_reg[1]));
        chk("C", 32'(C), 32'(m_reg[2]));
        chk("D", 32'(D), 32'(m_reg[3]));
        chk("WRITTEN", 32'(WRITTEN), 32'(m_written));
        chk("busy", 32'(busy), 32'(m_clr_left > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
    endtask

    task automatic fill_pattern();
        step(1'b0, 1'b0, 1'b1, 4'b0001, 2'd0);
        step(1'b0, 1'b0, 1'b1, 4'b0010, 2'd1);
        step(1'b0, 1'b0, 1'b1, 4'b0100, 2'd2);
        step(1'b0, 1'b0, 1'b1, 4'b1000, 2'd3);
    endtask

    logic [9:0] busy_hist;
    logic [3:0] wr_hist;

    initial begin
        rst = 1'b1; clr_req = 1'b0; wr_valid = 1'b0; DIN = '0; sel0 = 1'b0; sel1 = 1'b0;
        for (int i = 0; i < 4; i++) m_reg[i] = 4'h0;
        m_written  = 4'b0000;
        m_clr_left = 0;
        @(posedge clk);
        #1;

        // Reset state
        step(1'b1, 1'b0, 1'b0, 4'h0, 2'd0);
        step(1'b1, 1'b1, 1'b1, 4'hF, 2'd3);
        chk("reset_written", 32'(WRITTEN), 32'h0);

        // Scenario 1: fill all four registers
        fill_pattern();
        chk("s1_A", 32'(A), 32'h1);
        chk("s1_B", 32'(B), 32'h2);
        chk("s1_C", 32'(C), 32'h4);
        chk("s1_D", 32'(D), 32'h8);
        chk("s1_written", 32'(WRITTEN), 32'hF);

        // Scenario 2: rewrite C
        step(1'b0, 1'b0, 1'b1, 4'b1111, 2'd2);
        chk("s2_C", 32'(C), 32'hF);
        chk("s2_A", 32'(A), 32'h1);
        chk("s2_written", 32'(WRITTEN), 32'hF);

        // Scenario 3: one-cycle clr_req pulse, WRITTEN steps down
        fill_pattern();
        step(1'b0, 1'b1, 1'b0, 4'h0, 2'd0);
        step(1'b0, 1'b0, 1'b1, 4'h7, 2'd3);
        chk("s3_written1", 32'(WRITTEN), 32'hE);
        step(1'b0, 1'b0, 1'b1, 4'h7, 2'd3);
        chk("s3_written2", 32'(WRITTEN), 32'hC);
        step(1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
        chk("s3_written3", 32'(WRITTEN), 32'h8);
        step(1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
        chk("s3_written4", 32'(WRITTEN), 32'h0);
        chk("s3_busy_end", 32'(busy), 32'h0);
        idle(1);

        // Scenario 4: clr_req and wr_valid together
        step(1'b0, 1'b1, 1'b1, 4'b0101, 2'd1);
        chk("s4_B", 32'(B), 32'h0);
        chk("s4_busy", 32'(busy), 32'h1);
        idle(4);

        // Scenario 5: reset on the second CLEAR cycle
        fill_pattern();
        step(1'b0, 1'b1, 1'b0, 4'h0, 2'd0);
        step(1'b0, 1'b0, 1'b0, 4'h0, 2'd0);
        step(1'b1, 1'b0, 1'b0, 4'h0, 2'd0);
        chk("s5_written", 32'(WRITTEN), 32'h0);
        chk("s5_D", 32'(D), 32'h0);
        idle(1);

        // Scenario 6: clr_req held for 10 cycles
        fill_pattern();
        busy_hist = '0;
        wr_hist   = '0;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1, 4'h5, 2'(i));
            busy_hist = {busy_hist[8:0], busy};
        end
        chk("s6_busy_pattern", 32'(busy_hist), 32'b1111011110);
        chk("s6_written", 32'(WRITTEN), 32'h0);
        idle(1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 59) == 0),
                 ($urandom_range(0, 9) == 0),
                 ($urandom_range(0, 3) != 0),
                 4'($urandom),
                 2'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
